// File: rtl/ddr_maint_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : ddr_maint_pkg
//  Shared types and the round-robin picker for DRAM maintenance scheduling.
//  Revision : 1.0
// ============================================================================
package ddr_maint_pkg;

    // Types are sized for the largest supported configuration; modules slice down.
    localparam int MAX_RANKS         = 32;
    localparam int RANK_IDX_W        = $clog2(MAX_RANKS);
    localparam int MAX_PENDING_LIMIT = 255;

    typedef logic [RANK_IDX_W-1:0]                   rank_idx_t;
    typedef logic [$clog2(MAX_PENDING_LIMIT+1)-1:0]  pend_cnt_t;

    // First set bit of mask at or after ptr, wrapping within n ranks (0 if none).
    function automatic rank_idx_t rr_pick(input logic [MAX_RANKS-1:0] mask,
                                          input rank_idx_t ptr,
                                          input int n);
        rank_idx_t pick;
        logic      found;
        int        j;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_RANKS; k++) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if (k < n && !found && mask[j[RANK_IDX_W-1:0]]) begin
                pick  = j[RANK_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/refresh_interval_timer.sv
`default_nettype none
// ============================================================================
//  Module   : refresh_interval_timer
//  One rank's refresh interval counter; pulses tick on the last enabled cycle.
//  Revision : 1.0
// ============================================================================
module refresh_interval_timer #(
    parameter int REFI_CYCLES  = 640000,
    parameter int START_OFFSET = 0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    output logic tick
);

    localparam int            CW    = (REFI_CYCLES > 1) ? $clog2(REFI_CYCLES) : 1;
    localparam logic [CW-1:0] LAST  = CW'(REFI_CYCLES - 1);
    localparam logic [CW-1:0] START = CW'(START_OFFSET);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= START;
        end else if (tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/refresh_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : refresh_scheduler
//  Staggered per-rank refresh timers, postponement credits and an
//  urgency-first round-robin request offer with a held handshake.
//  Revision : 1.0
// ============================================================================
module refresh_scheduler
    import ddr_maint_pkg::*;
#(
    parameter int NUM_RANKS    = 4,
    parameter int REFI_CYCLES  = 640000,
    parameter int MAX_PENDING  = 8,
    parameter int URGENT_LEVEL = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    input  logic cmd_issued,
    output logic issue_cmd,
    output logic [((NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1)-1:0] issue_rank,
    output logic issue_urgent,
    output logic overflow
);

    localparam int            RW   = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;
    localparam int            PW   = $clog2(MAX_PENDING + 1);
    localparam logic [PW-1:0] PMAX = PW'(MAX_PENDING);

    logic [NUM_RANKS-1:0] tick;

    generate
        for (genvar gi = 0; gi < NUM_RANKS; gi++) begin : g_rank
            refresh_interval_timer #(
                .REFI_CYCLES  (REFI_CYCLES),
                .START_OFFSET (gi * (REFI_CYCLES / NUM_RANKS))
            ) u_timer (
                .clk    (clk),
                .n_rst  (n_rst),
                .enable (enable),
                .tick   (tick[gi])
            );
        end
    endgenerate

    logic [PW-1:0]        pending  [NUM_RANKS];
    logic [PW-1:0]        pend_nxt [NUM_RANKS];
    logic [RW-1:0]        rr_ptr, ptr_nxt, rank_nxt;
    logic [MAX_RANKS-1:0] live_mask, urgent_mask;
    logic [NUM_RANKS-1:0] sat_hit;
    logic                 ack, hit, cmd_nxt, urgent_nxt;
    rank_idx_t            pick;

    always_comb begin
        ack         = cmd_issued && issue_cmd;
        live_mask   = '0;
        urgent_mask = '0;
        sat_hit     = '0;
        hit         = 1'b0;
        for (int i = 0; i < NUM_RANKS; i++) begin
            hit         = ack && (issue_rank == RW'(i));
            pend_nxt[i] = pending[i];
            // A tick and an ack on the same rank cancel out.
            if (tick[i] && !hit) begin
                if (pending[i] == PMAX) sat_hit[i] = 1'b1;
                else                    pend_nxt[i] = pending[i] + 1'b1;
            end else if (!tick[i] && hit) begin
                pend_nxt[i] = pending[i] - 1'b1;
            end
            live_mask[i]   = (pend_nxt[i] != '0);
            urgent_mask[i] = (32'(pend_nxt[i]) >= URGENT_LEVEL);
        end

        if (ack) ptr_nxt = (issue_rank == RW'(NUM_RANKS - 1)) ? '0 : issue_rank + 1'b1;
        else     ptr_nxt = rr_ptr;

        pick = (|urgent_mask) ? rr_pick(urgent_mask, rank_idx_t'(ptr_nxt), NUM_RANKS)
                              : rr_pick(live_mask,   rank_idx_t'(ptr_nxt), NUM_RANKS);

        // A held offer is never preempted; reselect only when idle or acked.
        if (!issue_cmd || ack) begin
            cmd_nxt  = |live_mask;
            rank_nxt = pick[RW-1:0];
        end else begin
            cmd_nxt  = 1'b1;
            rank_nxt = issue_rank;
        end
        urgent_nxt = cmd_nxt && (32'(pend_nxt[rank_nxt]) >= URGENT_LEVEL);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_RANKS; i++) pending[i] <= '0;
            rr_ptr       <= '0;
            issue_cmd    <= 1'b0;
            issue_rank   <= '0;
            issue_urgent <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_RANKS; i++) pending[i] <= pend_nxt[i];
            rr_ptr       <= ptr_nxt;
            issue_cmd    <= cmd_nxt;
            issue_rank   <= rank_nxt;
            issue_urgent <= urgent_nxt;
            if (|sat_hit) overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire
